keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 50000, giving the clk cycles per column slot; legal range is 4 or more.
REQ-002 The module SHALL have parameter DEB_FRAMES, default 4, giving the consecutive identical frames required to accept a state; legal range is 1 to 15.
REQ-003 Port clk, input, 1 bit: single system clock; all logic runs on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port row_in, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 Port col_out, output, 4 bits: keypad column drive, active-low; exactly one bit is low at any time after reset.
REQ-007 Port onehot, output, 16 bits: debounced pressed-key vector, registered; bit index = row*4 + col; all zero when no key is pressed.
REQ-008 Port key_valid, output, 1 bit: one-cycle pulse when onehot takes a new non-zero value.
REQ-009 Port key_release, output, 1 bit: one-cycle pulse when onehot returns to zero from non-zero.

Function
REQ-010 Synchronisation: row_in SHALL pass through a 2-flop synchroniser before any use; its reset value is 4'hF.
REQ-011 Slot counter: counts 0 to SCAN_DIV-1 and wraps; a slot ends when the count is SCAN_DIV-1.
REQ-012 Column sequencing: col index steps 0,1,2,3,0 at each slot end; col_out = ~(4'b0001 << col).
REQ-013 Row sampling: the synchronised rows SHALL be sampled on the slot-end cycle, so settle time is SCAN_DIV-1 cycles.
REQ-014 Frame capture: the sample is inverted and written into frame bits {12+c, 8+c, 4+c, c} for column c.
REQ-015 Frame completion: a frame is complete at the slot end of column 3.
REQ-016 FSM states SHALL be SCAN, COMPARE and UPDATE.
REQ-017 SCAN -> COMPARE: on the cycle after frame completion.
REQ-018 COMPARE: if the frame equals the previous frame, stable_cnt increments, saturating at DEB_FRAMES; otherwise stable_cnt is set to 1 and the previous frame is replaced.
REQ-019 COMPARE -> UPDATE: taken when stable_cnt reaches DEB_FRAMES and the frame is either zero or one-hot; otherwise the FSM returns to SCAN.
REQ-020 UPDATE: if the frame differs from onehot, onehot is loaded and exactly one of key_valid or key_release pulses for one cycle; the FSM then returns to SCAN.
REQ-021 Multiple-key frames (popcount of 2 or more) SHALL never reach onehot; onehot holds its last accepted value.
REQ-022 Held key: a held key SHALL produce only one key_valid; a repeat needs a release first.
REQ-023 Key change: a change from key A directly to key B, once stable, SHALL load B and pulse key_valid without a key_release.
REQ-024 Latency: from a stable press, key_valid SHALL assert within (DEB_FRAMES+1)*4*SCAN_DIV+4 cycles.
REQ-025 Scan continuity: column scanning SHALL never stall; COMPARE and UPDATE overlap the next frame's slots.

Reset
REQ-026 rst_n low SHALL asynchronously clear all of the following: slot counter, col index (col_out=4'b1110), frame, previous frame, stable_cnt, onehot, key_valid and key_release; the FSM goes to SCAN.
REQ-027 Reset mid-frame SHALL discard the partial frame; debounce restarts from zero after release.

Structure
REQ-028 The shared keyboard package SHALL hold the FSM state enum, the column count (4), the row count (4) and the key-vector width (16).
REQ-029 A single sub-module, keypad_debounce, SHALL contain the COMPARE/UPDATE FSM and stable_cnt; the scan counter and column drive stay in keypad_scan.
REQ-030 onehot SHALL feed the downstream one-hot-to-binary converter unchanged.

Verification (SCAN_DIV=8, DEB_FRAMES=2 for sims)
REQ-031 Reset then idle rows 4'hF -> col_out cycles 1110,1101,1011,0111 every 8 clks; onehot=0; no pulses.
REQ-032 Press row1/col2, held -> onehot=16'h0040 and one key_valid within 100 clks; no further pulses while held.
REQ-033 Release after REQ-032 -> onehot=0 and one key_release pulse.
REQ-034 Press row0/col0 and row3/col3 together -> onehot stays 0; no pulses.
REQ-035 Row toggled each frame (bounce) for 10 frames, then stable row2/col1 -> a single key_valid with onehot=16'h0200 only after 2 stable frames.
REQ-036 rst_n low mid-frame while a key is held -> outputs clear immediately; after release of reset, key_valid re-asserts once after debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, debounce FSM states and key-vector helper.
package keypad_pkg;
  localparam int unsigned NCOL = 4;
  localparam int unsigned NROW = 4;
  localparam int unsigned NKEY = NROW * NCOL;
  typedef enum logic [1:0] {SCAN, COMPARE, UPDATE} deb_state_e;
  function automatic logic is_onehot0(input logic [NKEY-1:0] v);
    return (v & (v - {{(NKEY-1){1'b0}}, 1'b1})) == '0;
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce FSM; accepts only stable zero or single-key frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_done_i,
  input  logic [NKEY-1:0] frame_i,
  output logic [NKEY-1:0] onehot_o,
  output logic            key_valid_o,
  output logic            key_release_o
);
  localparam logic [3:0] DEB = 4'(DEB_FRAMES);
  deb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [NKEY-1:0] prev_q, prev_d, onehot_q, onehot_d;
  logic valid_q, valid_d, rel_q, rel_d, same;
  assign same = frame_i == prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SCAN;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == SCAN) ? (frame_done_i ? COMPARE : SCAN)
            : (state_q == COMPARE && cnt_d == DEB && is_onehot0(frame_i)) ? UPDATE : SCAN;
  end
  // prev_q holds the accepted-candidate frame, so UPDATE never depends on frame_i timing
  always_comb begin
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    onehot_d = onehot_q;
    valid_d  = 1'b0;
    rel_d    = 1'b0;
    if (state_q == COMPARE) begin
      cnt_d  = !same ? 4'd1 : (cnt_q == DEB ? DEB : cnt_q + 4'd1);
      prev_d = frame_i;
    end
    if (state_q == UPDATE && prev_q != onehot_q) begin
      onehot_d = prev_q;
      valid_d  = |prev_q;
      rel_d    = ~|prev_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      prev_q   <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      rel_q    <= rel_d;
    end
  end
  assign onehot_o      = onehot_q;
  assign key_valid_o   = valid_q;
  assign key_release_o = rel_q;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with row synchroniser and frame capture.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NROW-1:0] row_in,
  output logic [NCOL-1:0] col_out,
  output logic [NKEY-1:0] onehot,
  output logic            key_valid,
  output logic            key_release
);
  localparam int unsigned CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] col_q, col_d;
  logic [NROW-1:0] sync1_q, sync2_q;
  logic [NKEY-1:0] frame_q, frame_d;
  logic slot_end, frame_done;
  assign slot_end   = cnt_q == CW'(SCAN_DIV - 1);
  assign frame_done = slot_end && col_q == 2'd3;
  assign cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
  assign col_d      = slot_end ? col_q + 2'd1 : col_q;
  assign col_out    = ~(4'b0001 << col_q);
  // rows are sampled at the end of the slot, giving the column a full slot to settle
  always_comb begin
    frame_d = frame_q;
    for (int k = 0; k < NKEY; k++)
      if (slot_end && 2'(k % NCOL) == col_q) frame_d[k] = ~sync2_q[k/NCOL];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      cnt_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end
  keypad_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_done_i (frame_done),
    .frame_i      (frame_q),
    .onehot_o     (onehot),
    .key_valid_o  (key_valid),
    .key_release_o(key_release)
  );
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of scanning, debounce, multi-key rejection and reset.
module tb_keypad_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] row_in, col_out;
  logic [15:0] onehot, pressed = '0;
  logic key_valid, key_release;
  int total = 0, bad = 0, nv = 0, nr = 0, colbad = 0, v0, r0;
  always #5 clk = ~clk;
  keypad_scan #(.SCAN_DIV(8), .DEB_FRAMES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_in     (row_in),
    .col_out    (col_out),
    .onehot     (onehot),
    .key_valid  (key_valid),
    .key_release(key_release)
  );
  // keypad model: a row is pulled low when a pressed key sits on the driven column
  always_comb for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  always @(negedge clk) begin
    if (key_valid === 1'b1) nv++;
    if (key_release === 1'b1) nr++;
    if ($countones(~col_out) != 1) colbad++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_onehot", 32'(onehot), 32'h0);
    chk("rst_col", 32'(col_out), 32'he);
    rst_n = 1'b1;
    chk("col0_start", 32'(col_out), 32'he);
    repeat (7) @(negedge clk);
    chk("col0_end", 32'(col_out), 32'he);
    @(negedge clk);
    chk("col1", 32'(col_out), 32'hd);
    repeat (8) @(negedge clk);
    chk("col2", 32'(col_out), 32'hb);
    repeat (8) @(negedge clk);
    chk("col3", 32'(col_out), 32'h7);
    repeat (8) @(negedge clk);
    chk("col_wrap", 32'(col_out), 32'he);
    repeat (128) @(negedge clk);
    chk("idle_onehot", 32'(onehot), 32'h0);
    chk("idle_valid", 32'(nv), 32'd0);
    chk("idle_rel", 32'(nr), 32'd0);
    v0 = nv; r0 = nr;
    pressed = 16'h0040;
    repeat (100) @(negedge clk);
    chk("press_onehot", 32'(onehot), 32'h0040);
    chk("press_valid", 32'(nv - v0), 32'd1);
    repeat (160) @(negedge clk);
    chk("held_valid", 32'(nv - v0), 32'd1);
    chk("held_rel", 32'(nr - r0), 32'd0);
    v0 = nv; r0 = nr;
    pressed = '0;
    repeat (100) @(negedge clk);
    chk("rel_onehot", 32'(onehot), 32'h0);
    chk("rel_pulse", 32'(nr - r0), 32'd1);
    chk("rel_valid", 32'(nv - v0), 32'd0);
    v0 = nv; r0 = nr;
    pressed = 16'h8001;
    repeat (192) @(negedge clk);
    chk("multi_onehot", 32'(onehot), 32'h0);
    chk("multi_valid", 32'(nv - v0), 32'd0);
    pressed = '0;
    repeat (128) @(negedge clk);
    chk("multi_rel", 32'(nr - r0), 32'd0);
    chk("multi_onehot2", 32'(onehot), 32'h0);
    v0 = nv; r0 = nr;
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (32) @(negedge clk);
    end
    chk("bounce_valid", 32'(nv - v0), 32'd0);
    chk("bounce_onehot", 32'(onehot), 32'h0);
    pressed = 16'h0200;
    repeat (30) @(negedge clk);
    chk("early_valid", 32'(nv - v0), 32'd0);
    repeat (70) @(negedge clk);
    chk("stable_valid", 32'(nv - v0), 32'd1);
    chk("stable_onehot", 32'(onehot), 32'h0200);
    chk("bounce_rel", 32'(nr - r0), 32'd0);
    pressed = '0;
    repeat (100) @(negedge clk);
    chk("rel2_onehot", 32'(onehot), 32'h0);
    v0 = nv;
    pressed = 16'h0040;
    repeat (100) @(negedge clk);
    chk("pre_rst_valid", 32'(nv - v0), 32'd1);
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_onehot", 32'(onehot), 32'h0);
    chk("async_valid", 32'(key_valid), 32'h0);
    chk("async_rel", 32'(key_release), 32'h0);
    chk("async_col", 32'(col_out), 32'he);
    repeat (2) @(negedge clk);
    v0 = nv; r0 = nr;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_early", 32'(nv - v0), 32'd0);
    repeat (60) @(negedge clk);
    chk("post_rst_valid", 32'(nv - v0), 32'd1);
    chk("post_rst_onehot", 32'(onehot), 32'h0040);
    chk("post_rst_rel", 32'(nr - r0), 32'd0);
    chk("col_onelow", 32'(colbad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
